serial_addsub: RTL

//  Bit-serial two's-complement adder/subtractor for the CORDIC hyperbolic datapath.

---
 rtl/serial_addsub_if.sv | 25 ++
 rtl/serial_addsub.sv | 100 ++++++++++
 2 files changed

// File: rtl/serial_addsub_if.sv
// Request/result bundle for the bit-serial adder/subtractor.
// The master drives the operands and start; the slave returns status and result.
interface serial_addsub_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, carry_out, overflow
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, carry_out, overflow
  );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial two's-complement adder/subtractor: one full-adder slice and a carry flop,
// producing one result bit per clock, LSB first, for the CORDIC hyperbolic datapath.
module serial_addsub #(
  parameter int unsigned WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_addsub_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             s_bit;
  logic             maj;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    s_bit   = a_q[0] ^ b_q[0] ^ carry_q;
    maj     = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

    unique case (state_q)
      IDLE, DONE: begin
        // Subtraction is a + ~b + 1: invert b once at load and seed the carry with 1.
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = maj;
        res_d   = {s_bit, res_q[WIDTH-1:1]};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          // carry_q here is the carry into the MSB slice; maj is the carry out of it.
          cout_d  = maj;
          ovf_d   = carry_q ^ maj;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy      = (state_q == RUN);
  assign bus.done      = (state_q == DONE);
  assign bus.result    = res_q;
  assign bus.carry_out = cout_q;
  assign bus.overflow  = ovf_q;
endmodule
